// File: rtl/ps2_keyboard_rx_if.sv
// Output bundle of the PS/2 keyboard receiver: filtered make codes, shift state and error strobe.
interface ps2_keyboard_rx_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       shift_held;
  logic       frame_err;

  modport master (output scan_code, output scan_valid, output shift_held, output frame_err);
  modport slave  (input  scan_code, input  scan_valid, input  shift_held, input  frame_err);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end: synchronise, deframe 11-bit frames, filter to make codes, track shift.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat of the last emitted make code.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_keyboard_rx_if.master  kb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {D_NORM, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg, data_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s, data_s, fall;

  frame_state_t frame_state_reg;
  logic [2:0]   bit_cnt_reg;
  logic [7:0]   shift_reg;
  logic         parity_reg;
  logic [7:0]   byte_reg;
  logic         byte_strobe_reg;
  logic         frame_err_reg;
  logic [TW-1:0] to_cnt_reg;

  dec_state_t   dec_state_reg;
  logic         lshift_reg, rshift_reg, shift_held_reg;
  logic [7:0]   scan_code_reg;
  logic         scan_valid_reg;
  logic         emit_next;
  logic [7:0]   emit_code_next;
  logic [7:0]   brk_code_next;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0]   last_code_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= '0;
      data_sync_reg <= '0;
      clk_prev_reg  <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];
  assign fall   = clk_prev_reg & ~clk_s;

  // A falling edge takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state_reg <= F_IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_reg      <= 1'b0;
      byte_reg        <= '0;
      byte_strobe_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      to_cnt_reg      <= '0;
    end else begin
      byte_strobe_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      if (frame_state_reg == F_IDLE || fall) to_cnt_reg <= '0;
      else                                   to_cnt_reg <= to_cnt_reg + TW'(1);
      if (fall) begin
        case (frame_state_reg)
          F_IDLE: begin
            if (!data_s) begin
              frame_state_reg <= F_DATA;
              bit_cnt_reg     <= '0;
            end
          end
          F_DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) frame_state_reg <= F_PARITY;
          end
          F_PARITY: begin
            parity_reg      <= data_s;
            frame_state_reg <= F_STOP;
          end
          default: begin
            if (data_s && (^{shift_reg, parity_reg})) begin
              byte_reg        <= shift_reg;
              byte_strobe_reg <= 1'b1;
            end else begin
              frame_err_reg   <= 1'b1;
            end
            frame_state_reg <= F_IDLE;
          end
        endcase
      end else if (frame_state_reg != F_IDLE && to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_state_reg <= F_IDLE;
        frame_err_reg   <= 1'b1;
      end
    end
  end

  // Which accepted byte would be emitted, and which code a break refers to.
  always_comb begin
    emit_next      = 1'b0;
    emit_code_next = byte_reg;
    brk_code_next  = byte_reg;
    case (dec_state_reg)
      D_NORM: begin
        case (byte_reg)
          8'hE0, 8'hF0, 8'h12, 8'h59, 8'hAA, 8'hFA,
          8'hEE, 8'hFE, 8'h00, 8'hFF: emit_next = 1'b0;
          default:                    emit_next = 1'b1;
        endcase
      end
      D_EXT: begin
        if (byte_reg == 8'h4A) begin
          emit_next      = 1'b1;
          emit_code_next = 8'hE0;
        end else if (byte_reg == 8'h5A) begin
          emit_next      = 1'b1;
        end
      end
      D_EXT_BRK: begin
        if (byte_reg == 8'h4A)      brk_code_next = 8'hE0;
        else if (byte_reg != 8'h5A) brk_code_next = 8'h00;
      end
      default: ;
    endcase
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (emit_code_next == last_code_reg) emit_next = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state_reg  <= D_NORM;
      lshift_reg     <= 1'b0;
      rshift_reg     <= 1'b0;
      shift_held_reg <= 1'b0;
      scan_code_reg  <= '0;
      scan_valid_reg <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_code_reg  <= '0;
`endif
    end else begin
      scan_valid_reg <= 1'b0;
      if (byte_strobe_reg) begin
        if (emit_next) begin
          scan_code_reg  <= emit_code_next;
          scan_valid_reg <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          last_code_reg  <= emit_code_next;
`endif
        end
        case (dec_state_reg)
          D_NORM: begin
            case (byte_reg)
              8'hE0: dec_state_reg <= D_EXT;
              8'hF0: dec_state_reg <= D_BRK;
              8'h12: begin lshift_reg <= 1'b1; shift_held_reg <= 1'b1; end
              8'h59: begin rshift_reg <= 1'b1; shift_held_reg <= 1'b1; end
              default: ;
            endcase
          end
          D_EXT: dec_state_reg <= (byte_reg == 8'hF0) ? D_EXT_BRK : D_NORM;
          D_BRK: begin
            if (byte_reg == 8'h12) begin
              lshift_reg     <= 1'b0;
              shift_held_reg <= rshift_reg;
            end else if (byte_reg == 8'h59) begin
              rshift_reg     <= 1'b0;
              shift_held_reg <= lshift_reg;
            end
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (brk_code_next == last_code_reg) last_code_reg <= '0;
`endif
            dec_state_reg <= D_NORM;
          end
          default: begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (brk_code_next == last_code_reg) last_code_reg <= '0;
`endif
            dec_state_reg <= D_NORM;
          end
        endcase
      end
    end
  end

  assign kb.scan_code  = scan_code_reg;
  assign kb.scan_valid = scan_valid_reg;
  assign kb.shift_held = shift_held_reg;
  assign kb.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, expected events queued, monitor compares.
module tb_ps2_keyboard_rx;
  localparam int TO = 200;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if kb_if ();

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb       (kb_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 1 = emission, 2 = frame error
    logic [7:0] code;
    logic       sh;
    int         at;     // expected cycle, -1 = any
  } ev_t;

  ev_t q[$];
  int total = 0;
  int bad   = 0;

`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H - 1) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 = nothing expected, 1 = emission of code with shift sh, 2 = frame error
  task automatic send(input logic [7:0] b, input bit badpar, input int kind,
                      input logic [7:0] code, input bit sh);
    logic p;
    p = ~^b;
    if (badpar) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (H - 1) @(negedge clk);
    ps2_clk = 1'b0;
    if (kind == 1) q.push_back('{1, code, sh, cyc + 4});
    else if (kind == 2) q.push_back('{2, 8'h00, 1'b0, cyc + 3});
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every output strobe must match the oldest queued expectation.
  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (kb_if.scan_valid || kb_if.frame_err)) begin
        kind = {30'd0, kb_if.frame_err, kb_if.scan_valid};
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got valid=%b err=%b code=%h want none (cycle %0d)",
                   kb_if.scan_valid, kb_if.frame_err, kb_if.scan_code, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          if (e.kind == 1) begin
            chk("scan_code", kb_if.scan_code, e.code);
            chk("shift_at_emit", kb_if.shift_held, e.sh);
          end
          if (e.at >= 0) chk("event_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_scan_code", kb_if.scan_code, 8'h00);
    chk("reset_scan_valid", kb_if.scan_valid, 1'b0);
    chk("reset_shift_held", kb_if.shift_held, 1'b0);
    chk("reset_frame_err", kb_if.frame_err, 1'b0);

    // press and release A
    send(8'h1C, 0, 1, 8'h1C, 0);
    send(8'hF0, 0, 0, 8'h00, 0);
    send(8'h1C, 0, 0, 8'h00, 0);

    // left shift held around A
    send(8'h12, 0, 0, 8'h00, 0);
    chk("shift_after_lshift_make", kb_if.shift_held, 1'b1);
    send(8'h1C, 0, 1, 8'h1C, 1);
    send(8'hF0, 0, 0, 8'h00, 0);
    send(8'h12, 0, 0, 8'h00, 0);
    chk("shift_after_lshift_break", kb_if.shift_held, 1'b0);

    // extended keys
    send(8'hE0, 0, 0, 8'h00, 0);
    send(8'h4A, 0, 1, 8'hE0, 0);
    send(8'hE0, 0, 0, 8'h00, 0);
    send(8'hF0, 0, 0, 8'h00, 0);
    send(8'h4A, 0, 0, 8'h00, 0);
    send(8'hE0, 0, 0, 8'h00, 0);
    send(8'h75, 0, 0, 8'h00, 0);

    // parity error then recovery
    send(8'h1C, 1, 2, 8'h00, 0);
    send(8'h16, 0, 1, 8'h16, 0);

    // partial frame timeout then recovery
    q.push_back('{2, 8'h00, 1'b0, -1});
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    repeat (TO + 50) @(negedge clk);
    send(8'h45, 0, 1, 8'h45, 0);

    // status bytes are dropped
    send(8'hAA, 0, 0, 8'h00, 0);
    send(8'hFA, 0, 0, 8'h00, 0);

    // reset mid-frame with shift held
    send(8'h12, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_shift_held", kb_if.shift_held, 1'b0);
    chk("midrst_scan_code", kb_if.scan_code, 8'h00);
    send(8'h33, 0, 1, 8'h33, 0);

    // typematic repeat
    send(8'h1C, 0, 1, 8'h1C, 0);
    send(8'h1C, 0, FILT ? 0 : 1, 8'h1C, 0);
    send(8'h1C, 0, FILT ? 0 : 1, 8'h1C, 0);
    send(8'hF0, 0, 0, 8'h00, 0);
    send(8'h1C, 0, 0, 8'h00, 0);
    send(8'h1C, 0, 1, 8'h1C, 0);

    // right shift
    send(8'h59, 0, 0, 8'h00, 0);
    send(8'h1B, 0, 1, 8'h1B, 1);
    send(8'hF0, 0, 0, 8'h00, 0);
    send(8'h59, 0, 0, 8'h00, 0);
    chk("shift_after_rshift_break", kb_if.shift_held, 1'b0);

    repeat (60) @(negedge clk);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
